mshr_hazard_wakeup: RTL



---
 rtl/mshr_hazard_wakeup_pkg.sv | 25 ++
 rtl/mshr_hazard_wakeup_if.sv | 26 ++
 rtl/mshr_hazard_wakeup_rr_arb.sv | 59 +++++
 rtl/mshr_hazard_wakeup.sv | 104 ++++++++++
 4 files changed

// File: rtl/mshr_hazard_wakeup_pkg.sv
// Shared types and constants for the MSHR hazard wakeup tracker.
package mshr_hazard_wakeup_pkg;

    localparam int unsigned MSHR_ENTRY_NUM         = 8;
    localparam int unsigned MSHR_ENTRY_INDEX_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        READY  = 2'd2,
        ISSUED = 2'd3
    } wakeup_state_e;

    function automatic logic [MSHR_ENTRY_INDEX_WIDTH-1:0] onehot_to_index(
        input logic [MSHR_ENTRY_NUM-1:0] oh
    );
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MSHR_ENTRY_NUM; i++) begin
            if (oh[i]) idx = idx | MSHR_ENTRY_INDEX_WIDTH'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mshr_hazard_wakeup_if.sv
// Allocation, release and issue signals between MSHR control and the wakeup tracker.
interface mshr_hazard_wakeup_if;
    import mshr_hazard_wakeup_pkg::*;

    logic                                        alloc_vld;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]           alloc_index;
    logic [MSHR_ENTRY_NUM-1:0]                   alloc_dep_bitmap;
    logic [MSHR_ENTRY_NUM-1:0]                   v_release;
    logic                                        issue_rdy;
    logic                                        issue_vld;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0]           issue_index;
    logic [MSHR_ENTRY_NUM-1:0]                   v_entry_blocked;
    logic [MSHR_ENTRY_NUM-1:0][MSHR_ENTRY_NUM-1:0] v_dep_bitmap;
    logic                                        alloc_err;

    modport master (
        output alloc_vld, alloc_index, alloc_dep_bitmap, v_release, issue_rdy,
        input  issue_vld, issue_index, v_entry_blocked, v_dep_bitmap, alloc_err
    );

    modport slave (
        input  alloc_vld, alloc_index, alloc_dep_bitmap, v_release, issue_rdy,
        output issue_vld, issue_index, v_entry_blocked, v_dep_bitmap, alloc_err
    );

endinterface

// File: rtl/mshr_hazard_wakeup_rr_arb.sv
// Round-robin arbiter with registered pointer; a stalled grant is held until accepted or withdrawn.
module mshr_hazard_wakeup_rr_arb #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         gnt_rdy,
    output logic         gnt_vld_c,
    output logic [N-1:0] gnt_oh_c
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] hold_idx_q, hold_idx_d;
    logic          hold_q, hold_d;
    logic [IW-1:0] gnt_idx;
    logic          found;
    int unsigned   cand;

    always_comb begin
        gnt_vld_c  = |req;
        gnt_idx    = '0;
        found      = 1'b0;
        cand       = 0;
        // Keep presenting a stalled grant so the downstream sees a stable index
        if (hold_q && req[hold_idx_q]) begin
            gnt_idx = hold_idx_q;
            found   = 1'b1;
        end
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_q) + k) % N;
            if (!found && req[cand]) begin
                gnt_idx = IW'(cand);
                found   = 1'b1;
            end
        end
        gnt_oh_c   = gnt_vld_c ? (N'(1) << gnt_idx) : '0;
        hold_d     = gnt_vld_c && !gnt_rdy;
        hold_idx_d = gnt_idx;
        ptr_d      = ptr_q;
        if (gnt_vld_c && gnt_rdy) begin
            ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            hold_idx_q <= hold_idx_d;
        end
    end

endmodule

// File: rtl/mshr_hazard_wakeup.sv
// Per-entry blocker tracking: entries wait for older MSHRs to release, then issue one per cycle.
module mshr_hazard_wakeup
    import mshr_hazard_wakeup_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mshr_hazard_wakeup_if.slave  bus
);

    localparam int unsigned N  = MSHR_ENTRY_NUM;
    localparam int unsigned IW = MSHR_ENTRY_INDEX_WIDTH;

    wakeup_state_e       state_q [N];
    wakeup_state_e       state_d [N];
    logic [N-1:0][N-1:0] row_q, row_d;
    logic                err_q, err_d;

    logic [N-1:0] v_live, v_ready, v_wait;
    logic [N-1:0] alloc_oh, dep_eff, gnt_oh_c;
    logic         gnt_vld_c, handshake, alloc_ok;

    always_comb begin
        v_live  = '0;
        v_ready = '0;
        v_wait  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            v_live[i]  = state_q[i] != IDLE;
            v_ready[i] = state_q[i] == READY;
            v_wait[i]  = state_q[i] == WAIT;
        end
    end

    mshr_hazard_wakeup_rr_arb #(.N(N), .IW(IW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (v_ready),
        .gnt_rdy   (bus.issue_rdy),
        .gnt_vld_c (gnt_vld_c),
        .gnt_oh_c  (gnt_oh_c)
    );

    // Next state for every entry plus the dependency matrix
    always_comb begin
        alloc_oh  = N'(1) << bus.alloc_index;
        alloc_ok  = bus.alloc_vld && !v_live[bus.alloc_index] && !bus.v_release[bus.alloc_index];
        dep_eff   = bus.alloc_dep_bitmap & ~bus.v_release & ~alloc_oh & v_live;
        err_d     = err_q | (bus.alloc_vld & ~alloc_ok);
        handshake = gnt_vld_c & bus.issue_rdy;
        for (int unsigned i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            row_d[i]   = row_q[i] & ~bus.v_release;
            unique case (state_q[i])
                IDLE: begin
                    if (alloc_ok && alloc_oh[i]) begin
                        row_d[i]   = dep_eff;
                        state_d[i] = (|dep_eff) ? WAIT : READY;
                    end
                end
                WAIT: begin
                    if (bus.v_release[i]) begin
                        state_d[i] = IDLE;
                        row_d[i]   = '0;
                    end else if (row_d[i] == '0) begin
                        state_d[i] = READY;
                    end
                end
                READY: begin
                    if (bus.v_release[i]) begin
                        state_d[i] = IDLE;
                        row_d[i]   = '0;
                    end else if (handshake && gnt_oh_c[i]) begin
                        state_d[i] = ISSUED;
                    end
                end
                ISSUED: begin
                    if (bus.v_release[i]) begin
                        state_d[i] = IDLE;
                        row_d[i]   = '0;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) state_q[i] <= IDLE;
            row_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N; i++) state_q[i] <= state_d[i];
            row_q <= row_d;
            err_q <= err_d;
        end
    end

    assign bus.issue_vld       = gnt_vld_c;
    assign bus.issue_index     = onehot_to_index(gnt_oh_c);
    assign bus.v_entry_blocked = v_wait;
    assign bus.v_dep_bitmap    = row_q;
    assign bus.alloc_err       = err_q;

endmodule
